// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - per-channel PolarFire CCC PLL powerdown/lock sequencer
// Define PLL_SUP_LOSS_CNT_EN to implement the per-channel LOSS_COUNT counters.
module pll_lock_supervisor #(
  parameter int NUM_PLL          = 2,
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int PD_CYCLES        = 64,
  parameter int TIMEOUT_CYCLES   = 65536,
  parameter int STABLE_CYCLES    = 1024,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                 REF_CLK,
  input  logic                 RESET,
  input  logic [NUM_PLL-1:0]   ENABLE,
  input  logic [NUM_PLL-1:0]   PLL_LOCK,
  input  logic                 FAULT_CLR,
  output logic [NUM_PLL-1:0]   PLL_POWERDOWN_N,
  output logic [NUM_PLL-1:0]   PLL_READY,
  output logic [NUM_PLL-1:0]   PLL_FAULT,
  output logic                 ALL_READY,
  output logic [8*NUM_PLL-1:0] LOSS_COUNT
);

  localparam int MAX_A   = (PD_CYCLES > TIMEOUT_CYCLES) ? PD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] PD_MAX  = CW'(PD_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRIES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  genvar g;
  generate
    for (g = 0; g < NUM_PLL; g++) begin : g_ch
      logic [LOCK_SYNC_STAGES-1:0] sync;
      logic                        lk;
      logic [2:0]                  state;
      logic [2:0]                  state_nx;
      logic [CW-1:0]               cnt;
      logic [CW-1:0]               cnt_nx;
      logic [RW-1:0]               rty;
      logic [RW-1:0]               rty_nx;
      logic                        pd_q;
      logic                        rdy_q;
      logic                        flt_q;

      assign lk = sync[LOCK_SYNC_STAGES-1];

      always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
          sync <= '0;
        end else begin
          sync <= {sync[LOCK_SYNC_STAGES-2:0], PLL_LOCK[g]};
        end
      end

      always_comb begin
        state_nx = state;
        rty_nx   = rty;
        case (state)
          S_IDLE: begin
            if (ENABLE[g] && cnt == PD_MAX) state_nx = S_WAIT;
          end
          S_WAIT: begin
            if (!ENABLE[g]) begin
              state_nx = S_IDLE;
            end else if (lk) begin
              state_nx = S_STABLE;
            end else if (cnt == TO_LAST) begin
              rty_nx   = rty + RW'(1);
              state_nx = (rty_nx == RTY_MAX) ? S_FAULT : S_IDLE;
            end
          end
          S_STABLE: begin
            // A lock dropout here restarts the wait without charging a retry.
            if (!ENABLE[g]) begin
              state_nx = S_IDLE;
            end else if (!lk) begin
              state_nx = S_WAIT;
            end else if (cnt == ST_LAST) begin
              state_nx = S_READY;
              rty_nx   = '0;
            end
          end
          S_READY: begin
            if (!ENABLE[g] || !lk) state_nx = S_IDLE;
          end
          S_FAULT: begin
            if (FAULT_CLR) begin
              state_nx = S_IDLE;
              rty_nx   = '0;
            end
          end
          default: state_nx = S_IDLE;
        endcase

        if (state_nx != state) begin
          cnt_nx = '0;
        end else if ((state == S_IDLE && cnt != PD_MAX) || state == S_WAIT || state == S_STABLE) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          cnt_nx = cnt;
        end
      end

      // Outputs decode the next state so they change on the same edge as the FSM.
      always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
          state <= S_IDLE;
          cnt   <= '0;
          rty   <= '0;
          pd_q  <= 1'b0;
          rdy_q <= 1'b0;
          flt_q <= 1'b0;
        end else begin
          state <= state_nx;
          cnt   <= cnt_nx;
          rty   <= rty_nx;
          pd_q  <= (state_nx == S_WAIT) || (state_nx == S_STABLE) || (state_nx == S_READY);
          rdy_q <= (state_nx == S_READY);
          flt_q <= (state_nx == S_FAULT);
        end
      end

      assign PLL_POWERDOWN_N[g] = pd_q;
      assign PLL_READY[g]       = rdy_q;
      assign PLL_FAULT[g]       = flt_q;

`ifdef PLL_SUP_LOSS_CNT_EN
      logic       loss_evt;
      logic [7:0] loss_cnt;

      // A disable in the same cycle as the dropout is an orderly shutdown, not a loss.
      assign loss_evt = (state == S_READY) && ENABLE[g] && !lk;

      always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
          loss_cnt <= '0;
        end else if (loss_evt && loss_cnt != 8'hFF) begin
          loss_cnt <= loss_cnt + 8'd1;
        end
      end

      assign LOSS_COUNT[8*g +: 8] = loss_cnt;
`else
      assign LOSS_COUNT[8*g +: 8] = 8'd0;
`endif
    end
  endgenerate

  always_ff @(posedge REF_CLK or posedge RESET) begin
    if (RESET) begin
      ALL_READY <= 1'b0;
    end else begin
      ALL_READY <= (&(PLL_READY | ~ENABLE)) & (|ENABLE);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed and random checks against a timestamp-based model
module tb_pll_lock_supervisor;
  localparam int N  = 2;
  localparam int SS = 2;
  localparam int PD = 8;
  localparam int TO = 64;
  localparam int ST = 16;
  localparam int MR = 2;

`ifdef PLL_SUP_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] en;
  logic [N-1:0] lock;
  logic fclr;
  logic [N-1:0] pd_n;
  logic [N-1:0] rdy;
  logic [N-1:0] flt;
  logic all_rdy;
  logic [8*N-1:0] loss;

  pll_lock_supervisor #(
    .NUM_PLL(N), .LOCK_SYNC_STAGES(SS), .PD_CYCLES(PD),
    .TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST), .MAX_RETRIES(MR)
  ) dut (
    .REF_CLK(clk), .RESET(rst), .ENABLE(en), .PLL_LOCK(lock), .FAULT_CLR(fclr),
    .PLL_POWERDOWN_N(pd_n), .PLL_READY(rdy), .PLL_FAULT(flt),
    .ALL_READY(all_rdy), .LOSS_COUNT(loss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each channel is a phase plus the edge number at which it was entered.
  typedef enum {M_IDLE, M_WAIT, M_STABLE, M_READY, M_FAULT} mphase_t;
  mphase_t ph[N];
  int t_in[N];
  int rty_m[N];
  int loss_m[N];
  logic [N-1:0] lock_q[$];
  logic m_all;
  int cyc;

  function automatic void model_reset();
    cyc = 0;
    lock_q.delete();
    m_all = 1'b0;
    for (int i = 0; i < N; i++) begin
      ph[i] = M_IDLE; t_in[i] = 0; rty_m[i] = 0; loss_m[i] = 0;
    end
  endfunction

  function automatic void model_step();
    logic [N-1:0] lk;
    logic [N-1:0] rdy_prev;
    cyc++;
    lk = (lock_q.size() >= SS) ? lock_q[lock_q.size()-SS] : '0;
    lock_q.push_back(lock);
    if (lock_q.size() > SS) void'(lock_q.pop_front());
    for (int i = 0; i < N; i++) rdy_prev[i] = (ph[i] == M_READY);
    m_all = (&(rdy_prev | ~en)) & (|en);
    for (int i = 0; i < N; i++) begin
      int age;
      mphase_t nx;
      age = cyc - 1 - t_in[i];
      nx  = ph[i];
      case (ph[i])
        M_IDLE:   if (en[i] && age >= PD) nx = M_WAIT;
        M_WAIT: begin
          if (!en[i]) nx = M_IDLE;
          else if (lk[i]) nx = M_STABLE;
          else if (age == TO - 1) begin
            rty_m[i]++;
            nx = (rty_m[i] == MR) ? M_FAULT : M_IDLE;
          end
        end
        M_STABLE: begin
          if (!en[i]) nx = M_IDLE;
          else if (!lk[i]) nx = M_WAIT;
          else if (age == ST - 1) begin nx = M_READY; rty_m[i] = 0; end
        end
        M_READY: begin
          if (!en[i]) nx = M_IDLE;
          else if (!lk[i]) begin
            if (loss_m[i] < 255) loss_m[i]++;
            nx = M_IDLE;
          end
        end
        default: if (fclr) begin nx = M_IDLE; rty_m[i] = 0; end
      endcase
      if (nx != ph[i]) begin ph[i] = nx; t_in[i] = cyc; end
    end
  endfunction

  task automatic check_all();
    logic [N-1:0] e_pd, e_rdy, e_flt;
    logic [8*N-1:0] e_loss;
    for (int i = 0; i < N; i++) begin
      e_pd[i]  = (ph[i] == M_WAIT) || (ph[i] == M_STABLE) || (ph[i] == M_READY);
      e_rdy[i] = (ph[i] == M_READY);
      e_flt[i] = (ph[i] == M_FAULT);
      e_loss[8*i +: 8] = LOSS_EN ? 8'(loss_m[i]) : 8'd0;
    end
    check("pd_n", 64'(pd_n), 64'(e_pd));
    check("ready", 64'(rdy), 64'(e_rdy));
    check("fault", 64'(flt), 64'(e_flt));
    check("all_ready", 64'(all_rdy), 64'(m_all));
    check("loss_count", 64'(loss), 64'(e_loss));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; en = '0; lock = '0; fclr = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_pd_n", 64'(pd_n), 64'd0);
    check("reset_ready", 64'(rdy), 64'd0);
    check("reset_loss", 64'(loss), 64'd0);

    // Bring-up on channel 0
    en = 2'b01;
    do_reset();
    n = 0;
    do begin tick(); n++; end while (!pd_n[0] && n < 50);
    check("pd_rise_edge", 64'(n), 64'd9);
    for (int k = 0; k < 4; k++) tick();
    lock[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rdy[0] && n < 60);
    check("ready_latency", 64'(n), 64'd19);
    check("all_ready_lag", 64'(all_rdy), 64'd0);
    tick();
    check("all_ready_up", 64'(all_rdy), 64'd1);
    check("ch1_pd_off", 64'(pd_n[1]), 64'd0);

    // Timeout into fault, then clear
    lock = '0;
    do_reset();
    n = 0;
    do begin tick(); n++; end while (!flt[0] && n < 400);
    check("fault_edge", 64'(n), 64'd146);
    for (int k = 0; k < 200; k++) tick();
    check("fault_held", 64'({flt[0], pd_n[0]}), 64'b10);
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    check("fault_cleared", 64'(flt[0]), 64'd0);
    n = 0;
    do begin tick(); n++; end while (!pd_n[0] && n < 50);
    check("pd_after_clr", 64'(n), 64'd9);

    // Glitch while qualifying
    do_reset();
    n = 0;
    do begin tick(); n++; end while (!pd_n[0] && n < 50);
    lock[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 13; k++) begin tick(); n++; end
    lock[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); n++; end
    lock[0] = 1'b1;
    do begin tick(); n++; end while (!rdy[0] && n < 80);
    check("glitch_ready", 64'(n), 64'd35);

    // Loss in READY on channel 1
    en = 2'b10;
    lock[1] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rdy[1] && n < 100);
    check("ch1_ready", 64'(rdy[1]), 64'd1);
    lock[1] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (rdy[1] && n < 20);
    check("loss_latency", 64'(n), 64'd3);
    check("loss_pd_n", 64'(pd_n[1]), 64'd0);
    check("loss_one", 64'(loss[15:8]), LOSS_EN ? 64'd1 : 64'd0);

    // Disable in the same cycle the lock loss reaches the FSM
    lock[1] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rdy[1] && n < 100);
    tick();
    check("all_ready_ch1", 64'(all_rdy), 64'd1);
    lock[1] = 1'b0;
    tick();
    tick();
    en = 2'b00;
    tick();
    check("dis_ready", 64'(rdy[1]), 64'd0);
    check("dis_loss", 64'(loss[15:8]), LOSS_EN ? 64'd1 : 64'd0);
    check("dis_all_ready", 64'(all_rdy), 64'd0);

    // Saturation
    en = 2'b10;
    for (int k = 0; k < 299; k++) begin
      lock[1] = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!rdy[1] && n < 100);
      lock[1] = 1'b0;
      n = 0;
      do begin tick(); n++; end while (rdy[1] && n < 20);
    end
    check("loss_sat", 64'(loss[15:8]), LOSS_EN ? 64'd255 : 64'd0);

    // Asynchronous reset in STABLE
    en = 2'b01;
    lock = 2'b01;
    n = 0;
    do begin tick(); n++; end while (!pd_n[0] && n < 50);
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_pd_n", 64'(pd_n), 64'd0);
    check("arst_ready", 64'(rdy), 64'd0);
    check("arst_fault", 64'(flt), 64'd0);
    check("arst_all", 64'(all_rdy), 64'd0);
    check("arst_loss", 64'(loss), 64'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!pd_n[0] && n < 50);
    check("arst_restart", 64'(n), 64'd9);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(199) == 0) en[i] = ~en[i];
        if ($urandom_range(39) == 0) lock[i] = ~lock[i];
      end
      fclr = ($urandom_range(99) == 0);
      tick();
    end
    fclr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
